pipe_latch_m_wb: RTL

Parametrised MEM/WB pipeline latch with valid/ready flow control, stall back-pressure, synchronous flush and an optional two-entry skid buffer. It is the next generation of the plain MEM/WB latch: same payload (reg_write, mem_to_reg, ALU result, load data, destination register), generalised in width, with bubble tracking. It also presents the muxed writeback value and a qualified register-file write enable. It sits between the memory stage and the register-file write port.

---
 rtl/pipe_latch_m_wb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_latch_m_wb.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_latch_m_wb
//  Purpose  : MEM/WB pipeline latch with valid/ready flow control, flush,
//             bubble tracking and an optional two-entry skid buffer. Presents
//             the muxed writeback value and a qualified register-file write
//             enable that never targets register 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_latch_m_wb #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] data_load,
    input  logic [REG_AW-1:0] dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_write_reg,
    output logic              mem_to_reg_reg,
    output logic [DATA_W-1:0] alu_result_reg,
    output logic [DATA_W-1:0] data_load_reg,
    output logic [REG_AW-1:0] dst_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we
);

    // Payload packing: {reg_write, mem_to_reg, alu_result, data_load, dst}
    localparam int c_DST_LSB = 0;
    localparam int c_LD_LSB  = REG_AW;
    localparam int c_ALU_LSB = REG_AW + DATA_W;
    localparam int c_M2R_BIT = REG_AW + 2 * DATA_W;
    localparam int c_RW_BIT  = c_M2R_BIT + 1;
    localparam int c_PAY_W   = c_RW_BIT + 1;

    // Occupancy encoding {skid valid, head valid}
    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_ONE   = 2'b01;
    localparam logic [1:0] c_FULL  = 2'b11;

    logic               h_valid_q, h_valid_d;
    logic               s_valid_q, s_valid_d;
    logic [c_PAY_W-1:0] h_data_q,  h_data_d;
    logic [c_PAY_W-1:0] s_data_q,  s_data_d;

    logic [c_PAY_W-1:0] w_in_data;
    logic               w_accept;
    logic               w_drain;
    logic [1:0]         w_state;

    assign w_in_data = {reg_write, mem_to_reg, alu_result, data_load, dst};
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = h_valid_q & out_ready;
    assign w_state   = {s_valid_q, h_valid_q};

    // Next-state for head/skid entries; flush wins over any accept or drain
    always_comb begin
        h_valid_d = h_valid_q;
        s_valid_d = s_valid_q;
        h_data_d  = h_data_q;
        s_data_d  = s_data_q;
        if (flush) begin
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (SKID == 0) begin
            if (w_accept) begin
                h_data_d  = w_in_data;
                h_valid_d = 1'b1;
            end else if (w_drain) begin
                h_valid_d = 1'b0;
            end
        end else begin
            case (w_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        h_data_d  = w_in_data;
                        h_valid_d = 1'b1;
                    end
                end
                c_ONE: begin
                    if (w_accept && w_drain) begin
                        h_data_d = w_in_data;
                    end else if (w_accept) begin
                        s_data_d  = w_in_data;
                        s_valid_d = 1'b1;
                    end else if (w_drain) begin
                        h_valid_d = 1'b0;
                    end
                end
                c_FULL: begin
                    // in_ready is low here, so only a drain can move things
                    if (w_drain) begin
                        h_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                    end
                end
                default: begin
                    // Skid valid without head valid cannot occur; recover to empty
                    h_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Entry registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            h_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            s_valid_q <= s_valid_d;
            h_data_q  <= h_data_d;
            s_data_q  <= s_data_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic in_ready_q;
            // Registered ready: open whenever the skid slot will be free
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= ~s_valid_d;
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_comb_ready
            assign in_ready = ~h_valid_q | out_ready;
        end
    endgenerate

    assign out_valid      = h_valid_q;
    assign reg_write_reg  = h_valid_q & h_data_q[c_RW_BIT];
    assign mem_to_reg_reg = h_valid_q & h_data_q[c_M2R_BIT];
    assign alu_result_reg = h_data_q[c_ALU_LSB +: DATA_W];
    assign data_load_reg  = h_data_q[c_LD_LSB +: DATA_W];
    assign dst_reg        = h_data_q[c_DST_LSB +: REG_AW];
    assign wb_data        = mem_to_reg_reg ? data_load_reg : alu_result_reg;
    assign wb_we          = h_valid_q & out_ready & reg_write_reg & (|dst_reg);

endmodule
`default_nettype wire
